// File: rtl/interrupt_service_ctrl.sv
// Priority resolver, in-service register and two-pulse INTA sequencer of an 8259-style PIC.
// Decisions register one cycle after the sampled INTA edge; there is no backpressure, the CPU paces the handshake.
module interrupt_service_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] interrupt_request_register,
    input  logic [7:0] interrupt_mask,
    input  logic       inta_n,
    input  logic [4:0] vector_base,
    input  logic       aeoi_mode,
    input  logic       rotate_on_aeoi,
    input  logic       eoi_cmd,
    input  logic       eoi_specific,
    input  logic [2:0] eoi_level,
    input  logic       eoi_rotate,
    output logic       int_out,
    output logic [7:0] clear_IRR,
    output logic       freeze,
    output logic [7:0] in_service_register,
    output logic [7:0] vector_out,
    output logic       vector_oe
);

    typedef enum logic [1:0] {S_IDLE, S_ACK1, S_WAIT2, S_ACK2} state_t;

    state_t     state_q, state_d;
    logic       inta_q, inta_d;
    logic [2:0] priority_low_q, priority_low_d;
    logic [7:0] isr_q, isr_d;
    logic       int_out_q, int_out_d;
    logic [7:0] clear_irr_q, clear_irr_d;
    logic       freeze_q, freeze_d;
    logic       vector_oe_q, vector_oe_d;
    logic [2:0] level_q, level_d;
    logic       spurious_q, spurious_d;

    logic [7:0] pending;
    logic       pend_vld, isr_vld, eoi_hit;
    logic [2:0] pend_lvl, isr_lvl, eoi_lvl, pend_rank, isr_rank;
    logic       inta_fall, inta_rise;

    // Scan from lowest to highest priority so the last hit is the winner.
    function automatic logic [3:0] resolve(input logic [7:0] bits, input logic [2:0] plow);
        logic [3:0] r;
        logic [2:0] lvl;
        r = 4'b0;
        for (int i = 8; i >= 1; i--) begin
            lvl = plow + 3'(i);
            if (bits[lvl]) r = {1'b1, lvl};
        end
        return r;
    endfunction

    always_comb begin
        pending              = interrupt_request_register & ~interrupt_mask;
        {pend_vld, pend_lvl} = resolve(pending, priority_low_q);
        {isr_vld, isr_lvl}   = resolve(isr_q, priority_low_q);
        pend_rank            = pend_lvl - priority_low_q - 3'd1;
        isr_rank             = isr_lvl - priority_low_q - 3'd1;
        inta_fall            = inta_q & ~inta_n;
        inta_rise            = ~inta_q & inta_n;

        state_d        = state_q;
        inta_d         = inta_n;
        priority_low_d = priority_low_q;
        isr_d          = isr_q;
        int_out_d      = 1'b0;
        clear_irr_d    = 8'h00;
        freeze_d       = freeze_q;
        vector_oe_d    = vector_oe_q;
        level_d        = level_q;
        spurious_d     = spurious_q;
        eoi_hit        = 1'b0;
        eoi_lvl        = 3'd0;

        // EOI acts on the pre-update ISR; a same-cycle INTA set below overrides it.
        if (eoi_cmd) begin
            if (eoi_specific) begin
                eoi_hit = isr_q[eoi_level];
                eoi_lvl = eoi_level;
            end else begin
                eoi_hit = isr_vld;
                eoi_lvl = isr_lvl;
            end
            if (eoi_hit) begin
                isr_d[eoi_lvl] = 1'b0;
                if (eoi_rotate) priority_low_d = eoi_lvl;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (inta_fall) begin
                    level_d    = pend_vld ? pend_lvl : 3'd7;
                    spurious_d = ~pend_vld;
                    if (pend_vld) begin
                        isr_d[pend_lvl]       = 1'b1;
                        clear_irr_d[pend_lvl] = 1'b1;
                    end
                    freeze_d = 1'b1;
                    state_d  = S_ACK1;
                end else begin
                    int_out_d = pend_vld && (!isr_vld || (pend_rank < isr_rank));
                end
            end
            S_ACK1: begin
                if (inta_rise) state_d = S_WAIT2;
            end
            S_WAIT2: begin
                if (inta_fall) begin
                    vector_oe_d = 1'b1;
                    state_d     = S_ACK2;
                end
            end
            S_ACK2: begin
                if (inta_rise) begin
                    vector_oe_d = 1'b0;
                    freeze_d    = 1'b0;
                    if (aeoi_mode && !spurious_q) begin
                        isr_d[level_q] = 1'b0;
                        if (rotate_on_aeoi) priority_low_d = level_q;
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            inta_q         <= 1'b1;
            priority_low_q <= 3'd7;
            isr_q          <= 8'h00;
            int_out_q      <= 1'b0;
            clear_irr_q    <= 8'h00;
            freeze_q       <= 1'b0;
            vector_oe_q    <= 1'b0;
            level_q        <= 3'd0;
            spurious_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            inta_q         <= inta_d;
            priority_low_q <= priority_low_d;
            isr_q          <= isr_d;
            int_out_q      <= int_out_d;
            clear_irr_q    <= clear_irr_d;
            freeze_q       <= freeze_d;
            vector_oe_q    <= vector_oe_d;
            level_q        <= level_d;
            spurious_q     <= spurious_d;
        end
    end

    assign int_out             = int_out_q;
    assign clear_IRR           = clear_irr_q;
    assign freeze              = freeze_q;
    assign in_service_register = isr_q;
    assign vector_oe           = vector_oe_q;
    assign vector_out          = vector_oe_q ? {vector_base, level_q} : 8'h00;

endmodule

// File: tb/tb_interrupt_service_ctrl.sv
// Bench for interrupt_service_ctrl: directed scenarios then random traffic,
// clear pulses and vectors checked by a monitor against a queue-based scoreboard.
module tb_interrupt_service_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] irr = 8'h00;
    logic [7:0] imr = 8'h00;
    logic       inta_n = 1'b1;
    logic [4:0] vbase = 5'd0;
    logic       aeoi_mode = 1'b0;
    logic       rotate_on_aeoi = 1'b0;
    logic       eoi_cmd = 1'b0;
    logic       eoi_specific = 1'b0;
    logic [2:0] eoi_level = 3'd0;
    logic       eoi_rotate = 1'b0;
    logic       int_out;
    logic [7:0] clear_IRR;
    logic       freeze;
    logic [7:0] isr;
    logic [7:0] vector_out;
    logic       vector_oe;

    interrupt_service_ctrl dut (
        .clk                        (clk),
        .rst                        (rst),
        .interrupt_request_register (irr),
        .interrupt_mask             (imr),
        .inta_n                     (inta_n),
        .vector_base                (vbase),
        .aeoi_mode                  (aeoi_mode),
        .rotate_on_aeoi             (rotate_on_aeoi),
        .eoi_cmd                    (eoi_cmd),
        .eoi_specific               (eoi_specific),
        .eoi_level                  (eoi_level),
        .eoi_rotate                 (eoi_rotate),
        .int_out                    (int_out),
        .clear_IRR                  (clear_IRR),
        .freeze                     (freeze),
        .in_service_register        (isr),
        .vector_out                 (vector_out),
        .vector_oe                  (vector_oe)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [7:0] clr_q[$];
    logic [7:0] vec_q[$];
    logic [7:0] m_isr = 8'h00;
    int         m_plow = 7;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Position in the priority order: 0 = highest.
    function automatic int rank(input int lvl, input int plow);
        return (lvl - plow + 15) % 8;
    endfunction

    function automatic int top(input logic [7:0] bits, input int plow);
        int best;
        best = -1;
        for (int l = 0; l < 8; l++)
            if (bits[l] && (best < 0 || rank(l, plow) < rank(best, plow))) best = l;
        return best;
    endfunction

    function automatic logic exp_int();
        int hp, hi;
        hp = top(irr & ~imr, m_plow);
        hi = top(m_isr, m_plow);
        return (hp >= 0) && (hi < 0 || rank(hp, m_plow) < rank(hi, m_plow));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_int(input string name);
        tick();
        chk(name, 32'(int_out), 32'(exp_int()));
    endtask

    task automatic reset_model();
        m_isr  = 8'h00;
        m_plow = 7;
        vec_q.delete();
        clr_q.delete();
    endtask

    task automatic inta_seq(input bit abort_in_wait2);
        int l;
        bit spur;
        l = top(irr & ~imr, m_plow);
        spur = (l < 0);
        if (spur) l = 7;
        else begin
            m_isr[l] = 1'b1;
            clr_q.push_back(8'(1 << l));
        end
        vec_q.push_back({vbase, 3'(l)});
        inta_n = 1'b0;
        tick();
        chk("freeze_rise", 32'(freeze), 32'd1);
        chk("int_drop", 32'(int_out), 32'd0);
        chk("isr_set", 32'(isr), 32'(m_isr));
        tick();
        chk("clr_pending", 32'(clr_q.size()), 32'd0);
        inta_n = 1'b1;
        tick();
        if (abort_in_wait2) begin
            rst = 1'b0;
            #2;
            chk("rst_freeze", 32'(freeze), 32'd0);
            chk("rst_isr", 32'(isr), 32'd0);
            chk("rst_voe", 32'(vector_oe), 32'd0);
            chk("rst_clr", 32'(clear_IRR), 32'd0);
            reset_model();
            tick();
            rst = 1'b1;
            tick();
            return;
        end
        tick();
        inta_n = 1'b0;
        tick();
        chk("voe_rise", 32'(vector_oe), 32'd1);
        inta_n = 1'b1;
        tick();
        if (aeoi_mode && !spur) begin
            m_isr[l] = 1'b0;
            if (rotate_on_aeoi) m_plow = l;
        end
        chk("voe_fall", 32'(vector_oe), 32'd0);
        chk("freeze_fall", 32'(freeze), 32'd0);
        chk("isr_end", 32'(isr), 32'(m_isr));
        chk("vec_pending", 32'(vec_q.size()), 32'd0);
        if (!spur) irr[l] = 1'b0;
        check_int("int_reeval");
    endtask

    task automatic do_eoi(input bit spec, input int lvl, input bit rot);
        int c;
        c = -1;
        if (spec) begin
            if (m_isr[lvl]) c = lvl;
        end else c = top(m_isr, m_plow);
        if (c >= 0) begin
            m_isr[c] = 1'b0;
            if (rot) m_plow = c;
        end
        eoi_cmd = 1'b1;
        eoi_specific = spec;
        eoi_level = 3'(lvl);
        eoi_rotate = rot;
        tick();
        eoi_cmd = 1'b0;
        eoi_rotate = 1'b0;
        chk("eoi_isr", 32'(isr), 32'(m_isr));
    endtask

    logic [7:0] clr_prev = 8'h00;
    logic       voe_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            clr_prev <= 8'h00;
            voe_prev <= 1'b0;
        end else begin
            if (clear_IRR != 8'h00) begin
                if (clr_prev != 8'h00) chk("clr_width", 32'(clr_prev), 32'd0);
                else if (clr_q.size() == 0) chk("clr_unexpected", 32'(clear_IRR), 32'd0);
                else chk("clear_IRR", 32'(clear_IRR), 32'(clr_q.pop_front()));
            end
            if (vector_oe && !voe_prev) begin
                if (vec_q.size() == 0) chk("vec_unexpected", 32'(vector_oe), 32'd0);
                else chk("vector_out", 32'(vector_out), 32'(vec_q.pop_front()));
            end
            clr_prev <= clear_IRR;
            voe_prev <= vector_oe;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        #3;
        chk("rst_int", 32'(int_out), 32'd0);
        chk("rst_clr0", 32'(clear_IRR), 32'd0);
        chk("rst_freeze0", 32'(freeze), 32'd0);
        chk("rst_isr0", 32'(isr), 32'd0);
        chk("rst_vec0", 32'(vector_out), 32'd0);
        chk("rst_voe0", 32'(vector_oe), 32'd0);
        tick();
        rst = 1'b1;
        check_int("idle_empty");

        // Basic acknowledge: IR2 wins over IR5, vector 0x42.
        vbase = 5'h08;
        irr = 8'h24;
        check_int("int_basic");
        chk("int_basic_const", 32'(int_out), 32'd1);
        inta_seq(0);
        chk("isr_basic", 32'(isr), 32'h04);

        // Nesting: lower level held off, higher level interrupts.
        irr = 8'h20;
        check_int("nest_low");
        irr = 8'h01;
        check_int("nest_high");
        irr = 8'h00;
        do_eoi(0, 0, 0);

        // Masked request and spurious acknowledge.
        imr = 8'h04;
        irr = 8'h04;
        check_int("masked");
        inta_seq(0);
        imr = 8'h00;
        irr = 8'h00;

        // Build ISR=0x12, then non-specific, specific and empty EOIs.
        irr = 8'h10;
        inta_seq(0);
        irr = 8'h02;
        check_int("nest_ir1");
        inta_seq(0);
        chk("isr_12", 32'(isr), 32'h12);
        do_eoi(0, 0, 0);
        chk("isr_10", 32'(isr), 32'h10);
        do_eoi(1, 4, 0);
        do_eoi(0, 0, 0);
        chk("isr_empty", 32'(isr), 32'h00);

        // AEOI with rotation: IR3 becomes lowest, so IR4 beats IR0.
        aeoi_mode = 1'b1;
        rotate_on_aeoi = 1'b1;
        irr = 8'h08;
        inta_seq(0);
        chk("aeoi_isr", 32'(isr), 32'h00);
        irr = 8'h11;
        check_int("rot_int");
        inta_seq(0);
        aeoi_mode = 1'b0;
        rotate_on_aeoi = 1'b0;

        // Reset in WAIT2, then the basic sequence again.
        irr = 8'h24;
        check_int("pre_abort");
        inta_seq(1);
        irr = 8'h24;
        check_int("post_abort_int");
        inta_seq(0);
        chk("post_abort_isr", 32'(isr), 32'h04);

        for (int it = 0; it < 60; it++) begin
            irr = 8'($urandom);
            imr = 8'($urandom & $urandom);
            vbase = 5'($urandom);
            aeoi_mode = 1'($urandom_range(0, 1));
            rotate_on_aeoi = 1'($urandom_range(0, 1));
            check_int("rand_int");
            if ($urandom_range(0, 2) != 0) inta_seq(0);
            if ($urandom_range(0, 1) != 0)
                do_eoi(1'($urandom_range(0, 1)), $urandom_range(0, 7), 1'($urandom_range(0, 1)));
            check_int("rand_int_post");
        end

        tick();
        chk("clr_q_empty", 32'(clr_q.size()), 32'd0);
        chk("vec_q_empty", 32'(vec_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
